// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-port RAM arbiter: FSM/owner states and port indices.
package mem_arb_pkg;

    // State encoding doubles as the debug owner output.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } arb_state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    function automatic arb_state_e own_state(input logic idx);
        return (idx == PORT1) ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/rr_lock_sel.sv
// Combinational winner pick: round-robin between requesters, honouring a bounded lock.
module rr_lock_sel
    import mem_arb_pkg::*;
#(
    parameter int LOCK_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  arb_state_e       i_state,
    input  logic [CNT_W-1:0] i_lock_cnt,
    input  logic             i_rr_last,
    input  logic [1:0]       i_req,
    output logic             o_gnt_vld,
    output logic             o_gnt_idx
);

    logic w_own_vld;
    logic w_own_idx;

    always_comb begin
        w_own_vld = 1'b0;
        w_own_idx = PORT0;
        case (i_state)
            ST_OWN0: begin w_own_vld = 1'b1; w_own_idx = PORT0; end
            ST_OWN1: begin w_own_vld = 1'b1; w_own_idx = PORT1; end
            default: ;
        endcase
    end

    always_comb begin
        o_gnt_vld = |i_req;
        o_gnt_idx = (&i_req) ? ~i_rr_last : i_req[1];
        // An owner that dropped its request falls through to the plain round-robin pick.
        if (w_own_vld && i_req[w_own_idx]) begin
            if (i_req[~w_own_idx] && (i_lock_cnt == CNT_W'(LOCK_MAX)))
                o_gnt_idx = ~w_own_idx;
            else
                o_gnt_idx = w_own_idx;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one RAM between the CPU (port 0) and a DMA/loader (port 1), one access per cycle.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int LOCK_MAX   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic                  m0_lock,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic                  m1_lock,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  ram_re,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [1:0]            owner
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_e       r_state;
    logic [CNT_W-1:0] r_lock_cnt;
    logic             r_rr_last;
    logic [1:0]       r_rvalid;

    logic                  w_gnt_vld;
    logic                  w_gnt_idx;
    logic                  w_ack;
    logic                  w_we;
    logic                  w_lock;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;

    rr_lock_sel #(
        .LOCK_MAX (LOCK_MAX),
        .CNT_W    (CNT_W)
    ) u_sel (
        .i_state    (r_state),
        .i_lock_cnt (r_lock_cnt),
        .i_rr_last  (r_rr_last),
        .i_req      ({m1_req, m0_req}),
        .o_gnt_vld  (w_gnt_vld),
        .o_gnt_idx  (w_gnt_idx)
    );

    assign w_ack   = w_gnt_vld & ~rst;
    assign w_we    = (w_gnt_idx == PORT1) ? m1_we    : m0_we;
    assign w_lock  = (w_gnt_idx == PORT1) ? m1_lock  : m0_lock;
    assign w_addr  = (w_gnt_idx == PORT1) ? m1_addr  : m0_addr;
    assign w_wdata = (w_gnt_idx == PORT1) ? m1_wdata : m0_wdata;

    assign m0_ack    = w_ack & (w_gnt_idx == PORT0);
    assign m1_ack    = w_ack & (w_gnt_idx == PORT1);
    assign ram_re    = w_ack & ~w_we;
    assign ram_we    = w_ack & w_we;
    assign ram_addr  = w_ack ? w_addr  : '0;
    assign ram_wdata = w_ack ? w_wdata : '0;

    assign m0_rvalid = r_rvalid[0];
    assign m1_rvalid = r_rvalid[1];
    assign m0_rdata  = r_rvalid[0] ? ram_rdata : '0;
    assign m1_rdata  = r_rvalid[1] ? ram_rdata : '0;
    assign owner     = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_lock_cnt <= '0;
            r_rr_last  <= PORT1;
            r_rvalid   <= '0;
        end else begin
            r_rvalid <= {m1_ack & ~m1_we, m0_ack & ~m0_we};
            if (w_ack && w_lock) begin
                r_rr_last <= w_gnt_idx;
                r_state   <= own_state(w_gnt_idx);
                // Saturate so an uncontended owner is released as soon as a contender shows up.
                if (r_state == own_state(w_gnt_idx))
                    r_lock_cnt <= (r_lock_cnt == CNT_W'(LOCK_MAX)) ? r_lock_cnt
                                                                  : r_lock_cnt + CNT_W'(1);
                else
                    r_lock_cnt <= CNT_W'(1);
            end else begin
                if (w_ack)
                    r_rr_last <= w_gnt_idx;
                r_state    <= ST_IDLE;
                r_lock_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified RAM between two requesters: port 0 is the CPU (fetch and LOAD/STR accesses) and port 1 is a DMA/program-loader master.
- Arbitration is round-robin, one access per cycle, with an optional bounded lock so a master can keep consecutive accesses.
- Sits between the CPU memory-access logic and the RAM instance. Replaces the direct CPU→RAM wiring.

Parameters:
- DATA_WIDTH, 16, RAM word width.
- ADDR_WIDTH, 16, RAM address width.
- LOCK_MAX, 8, maximum consecutive locked grants to one port before a forced fairness release (≥1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mN_req  in  1  request, N∈{0,1}. Held with fields stable until acked.
- mN_we  in  1  1=write, 0=read.
- mN_lock  in  1  request to keep ownership after this access.
- mN_addr  in  ADDR_WIDTH  access address.
- mN_wdata  in  DATA_WIDTH  write data.
- mN_ack  out  1  access performed this cycle (combinational).
- mN_rvalid  out  1  read data valid (registered, cycle after ack).
- mN_rdata  out  DATA_WIDTH  read data. Qualified by rvalid, 0 otherwise.
- ram_re  out  1  RAM read enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after ram_re.
- owner  out  2  debug: 00 idle, 01 port0 locked, 10 port1 locked.

Behaviour:
Reset values:
- All ack/rvalid/ram_re/ram_we = 0. rdata = 0. ram_addr/ram_wdata = 0.
- FSM = IDLE, lock_cnt = 0, rr_last = 1 (so port 0 wins the first tie).
- While rst is high, all acks and RAM enables are forced 0.

FSM states:
- IDLE: no ownership.
- OWN0: port 0 holds the lock.
- OWN1: port 1 holds the lock.

Winner selection (combinational, every cycle):
- IDLE:
  - Only one req → that port wins.
  - Both req → port ≠ rr_last wins.
  - None → no access.
- OWNn:
  - If mn_req=1, port n wins, unless lock_cnt==LOCK_MAX and the other port is requesting; then the other port wins.
  - If mn_req=0, fall back to the IDLE rule in the same cycle (ownership is dropped).

Access and handshake:
- Winner: ack=1. ram_re=!we, ram_we=we. ram_addr/ram_wdata are muxed from the winner.
- Loser: ack=0 and must keep req and fields stable.
- RAM writes commit at the clock edge of the ack cycle.
- Reads: rvalid pulses exactly 1 cycle after the ack. rdata = ram_rdata during that cycle.
- Back-to-back reads from the same port give a continuous rvalid.

Sequential updates on an ack edge:
- rr_last ← winner.
- Winner's lock=1, winning via ownership or IDLE → next state OWNwinner.
  - lock_cnt ← lock_cnt+1 if the state was already OWNwinner, else 1.
- lock=0 → IDLE, lock_cnt ← 0.
- Forced fairness release → state OWN/IDLE per the new winner's lock; lock_cnt restarts.
- No ack → IDLE, lock_cnt ← 0.

Boundary conditions:
- Same port repeatedly requesting while the other is idle: granted every cycle. The lock limit only applies when the other port is contending.
- Reset mid-read: the pending rvalid is suppressed (it is cleared asynchronously).
- Write followed by a read of the same address, either port: the read returns the new data.
- Simultaneous write requests to the same address: serialized in round-robin order; the last writer's data persists.

Decomposition:
- Shared package mem_arb_pkg holds:
  - FSM state encoding (IDLE=2'b00, OWN0=2'b01, OWN1=2'b10), which is also the owner encoding.
  - Port index constants.
- One natural sub-module: rr_lock_sel, the combinational winner selection from {state, lock_cnt, rr_last, reqs}.
- Datapath muxing and registers stay in the top.

Test Plan:
1. Reset, then m0 read addr 0x0004 alone, RAM[4]=0xBEEF → m0_ack in cycle 1; m0_rvalid=1 with m0_rdata=0xBEEF in cycle 2; m1 outputs all 0.
2. Both req every cycle, no lock → acks alternate m0,m1,m0,m1 starting with m0; ram_addr alternates accordingly.
3. m1 lock=1 continuously with m0 also requesting, LOCK_MAX=8 → m1 acked 8 consecutive cycles, then m0 acked one cycle, then m1 resumes; owner goes 10→00/10 as specified.
4. m0 write 0x1234 to 0x0010, next cycle m1 read 0x0010 → m1_rdata=0x1234 with rvalid.
5. Assert rst asynchronously during the cycle after an m0 read ack → m0_rvalid drops immediately; after release m0 wins the first tie.
6. m0 lock then m0 drops req while m1 requests → m1 acked the same cycle; state returns through IDLE.
